// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the write-back trap sequencer.
//   - trap cause codes (exceptions and machine interrupts)
//   - mtvec mode encodings
//   - FSM state encoding used by trap_ctrl
package trap_pkg;

  localparam logic [4:0] CAUSE_INST_MIS = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
  localparam logic [4:0] CAUSE_LD_MIS   = 5'd4;
  localparam logic [4:0] CAUSE_ST_MIS   = 5'd6;
  localparam logic [4:0] CAUSE_MSI      = 5'd3;
  localparam logic [4:0] CAUSE_MTI      = 5'd7;
  localparam logic [4:0] CAUSE_MEI      = 5'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_JUMP = 2'd2,
    ST_MRET = 2'd3
  } state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: combinational fixed-priority trap cause encoder.
// Inputs : exception flags, WB instruction/address, interrupt pending lines,
//          interrupt enables {meie,mtie,msie}, global mstatus.MIE.
// Outputs: trap_valid - some exception or enabled interrupt is present
//          is_irq     - the selected trap is an interrupt (no exception present)
//          cause      - selected cause code
//          tval       - trap value (0 for interrupts)
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic        e_inst_addr_mis,
  input  logic        e_illegal_inst,
  input  logic        e_ld_addr_mis,
  input  logic        e_st_addr_mis,
  input  logic [31:0] inst,
  input  logic [31:0] mem_addr,
  input  logic        meip,
  input  logic        mtip,
  input  logic        msip,
  input  logic [2:0]  mie,
  input  logic        mstatus_mie,
  output logic        trap_valid,
  output logic        is_irq,
  output logic [4:0]  cause,
  output logic [31:0] tval
);

  logic [2:0] irq_act;  // {MEI, MTI, MSI} pending and enabled
  assign irq_act = {meip, mtip, msip} & mie;

  always_comb begin
    trap_valid = 1'b1;
    is_irq     = 1'b0;
    cause      = '0;
    tval       = '0;
    if (e_inst_addr_mis) begin
      cause = CAUSE_INST_MIS;
      tval  = mem_addr;
    end else if (e_illegal_inst) begin
      cause = CAUSE_ILLEGAL;
      tval  = inst;
    end else if (e_ld_addr_mis) begin
      cause = CAUSE_LD_MIS;
      tval  = mem_addr;
    end else if (e_st_addr_mis) begin
      cause = CAUSE_ST_MIS;
      tval  = mem_addr;
    end else if (mstatus_mie && (irq_act != 3'b000)) begin
      is_irq = 1'b1;
      // MSI outranks MTI even though its enable bit sits lower.
      if (irq_act[2])      cause = CAUSE_MEI;
      else if (irq_act[0]) cause = CAUSE_MSI;
      else                 cause = CAUSE_MTI;
    end else begin
      trap_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: write-back trap sequencer.
// Picks one trap cause for the WB instruction, then sequences
//   detect (flush) -> SAVE (CSR write strobe, stall) -> JUMP (redirect to mtvec)
// and for mret
//   detect (flush) -> MRET (mret strobe, redirect to mepc).
// Ports: clk_i/rst_i (async, active-high); WB instruction info and exception
// flags; interrupt lines and enables; mtvec/mepc CSRs; flush/stall, CSR write
// strobe with mcause/mepc/mtval, mret strobe, PC redirect strobe and target.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter bit VEC_MODE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  logic [31:0] wb_inst_i,
  input  logic [31:0] wb_mem_addr_i,
  input  logic        e_inst_addr_mis_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_ld_addr_mis_i,
  input  logic        e_st_addr_mis_i,
  input  logic        is_mret_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic        mstatus_mie_i,
  input  logic [2:0]  mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        flush_o,
  output logic        stall_o,
  output logic        csr_we_exc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic        mret_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o
);

  state_t      state, nxt;
  logic        trap_valid, is_irq;
  logic [4:0]  cause;
  logic [31:0] tval;
  logic [4:0]  cause_q;
  logic        irq_q;
  logic [31:0] tval_q, epc_q;
  logic        take_trap, take_mret, capture, flush_idle;
  logic [31:0] base;

  trap_prio_enc u_enc (
    .e_inst_addr_mis (e_inst_addr_mis_i),
    .e_illegal_inst  (e_illegal_inst_i),
    .e_ld_addr_mis   (e_ld_addr_mis_i),
    .e_st_addr_mis   (e_st_addr_mis_i),
    .inst            (wb_inst_i),
    .mem_addr        (wb_mem_addr_i),
    .meip            (xint_meip_i),
    .mtip            (xint_mtip_i),
    .msip            (xint_msip_i),
    .mie             (mie_i),
    .mstatus_mie     (mstatus_mie_i),
    .trap_valid      (trap_valid),
    .is_irq          (is_irq),
    .cause           (cause),
    .tval            (tval)
  );

  // Exceptions beat mret; mret beats interrupts (re-evaluated after return).
  assign take_mret = is_mret_i & ~(trap_valid & ~is_irq);
  assign take_trap = trap_valid & ~(is_irq & is_mret_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cause_q <= '0;
      irq_q   <= 1'b0;
      tval_q  <= '0;
      epc_q   <= '0;
    end else if (capture) begin
      cause_q <= cause;
      irq_q   <= is_irq;
      tval_q  <= tval;
      epc_q   <= wb_pc_i;
    end
  end

  always_comb begin
    nxt        = state;
    capture    = 1'b0;
    flush_idle = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wb_valid_i) begin
          if (take_trap) begin
            flush_idle = 1'b1;
            capture    = 1'b1;
            nxt        = ST_SAVE;
          end else if (take_mret) begin
            flush_idle = 1'b1;
            nxt        = ST_MRET;
          end
        end
      end
      ST_SAVE: nxt = ST_JUMP;
      ST_JUMP: nxt = ST_IDLE;
      ST_MRET: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // The IDLE flush is combinational from WB inputs; gate it so reset forces
  // every output low immediately.
  assign flush_o       = ~rst_i & (flush_idle | (state != ST_IDLE));
  assign stall_o       = (state == ST_SAVE);
  assign csr_we_exc_o  = (state == ST_SAVE);
  assign mret_o        = (state == ST_MRET);
  assign pc_redirect_o = (state == ST_JUMP) | (state == ST_MRET);
  assign mcause_o      = {irq_q, 26'd0, cause_q};
  assign mepc_o        = epc_q;
  assign mtval_o       = tval_q;

  assign base = {mtvec_i[31:2], 2'b00};

  always_comb begin
    pc_target_o = '0;
    if (state == ST_JUMP) begin
      // Modes 2/3 fall back to direct; exceptions always use the base.
      if (VEC_MODE_EN && irq_q && (mtvec_i[1:0] == MTVEC_VECTORED))
        pc_target_o = base + {25'd0, cause_q, 2'b00};
      else
        pc_target_o = base;
    end else if (state == ST_MRET) begin
      pc_target_o = {mepc_i[31:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: two instances (vectored support on and off) share
// stimulus; a sequence-level model predicts every output each cycle.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_valid_i = 1'b0;
  logic [31:0] wb_pc_i = '0, wb_inst_i = '0, wb_mem_addr_i = '0;
  logic        e_ia = 1'b0, e_ill = 1'b0, e_ld = 1'b0, e_st = 1'b0;
  logic        is_mret_i = 1'b0;
  logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
  logic        mstatus_mie_i = 1'b0;
  logic [2:0]  mie_i = '0;
  logic [31:0] mtvec_i = '0, mepc_i = '0;

  logic        flush_v, stall_v, we_v, mret_v, redir_v;
  logic [31:0] mcause_v, mepc_v, mtval_v, tgt_v;
  logic        flush_d, stall_d, we_d, mret_d, redir_d;
  logic [31:0] mcause_d, mepc_d, mtval_d, tgt_d;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.VEC_MODE_EN(1'b1)) dut_v (
    .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .wb_inst_i(wb_inst_i), .wb_mem_addr_i(wb_mem_addr_i),
    .e_inst_addr_mis_i(e_ia), .e_illegal_inst_i(e_ill), .e_ld_addr_mis_i(e_ld),
    .e_st_addr_mis_i(e_st), .is_mret_i(is_mret_i), .xint_meip_i(meip),
    .xint_mtip_i(mtip), .xint_msip_i(msip), .mstatus_mie_i(mstatus_mie_i),
    .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .flush_o(flush_v), .stall_o(stall_v), .csr_we_exc_o(we_v),
    .mcause_o(mcause_v), .mepc_o(mepc_v), .mtval_o(mtval_v), .mret_o(mret_v),
    .pc_redirect_o(redir_v), .pc_target_o(tgt_v));

  trap_ctrl #(.VEC_MODE_EN(1'b0)) dut_d (
    .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .wb_inst_i(wb_inst_i), .wb_mem_addr_i(wb_mem_addr_i),
    .e_inst_addr_mis_i(e_ia), .e_illegal_inst_i(e_ill), .e_ld_addr_mis_i(e_ld),
    .e_st_addr_mis_i(e_st), .is_mret_i(is_mret_i), .xint_meip_i(meip),
    .xint_mtip_i(mtip), .xint_msip_i(msip), .mstatus_mie_i(mstatus_mie_i),
    .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .flush_o(flush_d), .stall_o(stall_d), .csr_we_exc_o(we_d),
    .mcause_o(mcause_d), .mepc_o(mepc_d), .mtval_o(mtval_d), .mret_o(mret_d),
    .pc_redirect_o(redir_d), .pc_target_o(tgt_d));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each entry is what one future cycle must show; an empty queue means the
  // controller is free and the current WB inputs decide.
  typedef struct packed {
    logic        flush, stall, we, mret, redir;
    logic [31:0] mcause, mepc, mtval;
    logic        to_mepc;
    logic        irq;
    logic [4:0]  cause;
  } exp_t;

  exp_t q[$];

  function automatic logic [31:0] target(exp_t e, bit vec);
    logic [31:0] b;
    if (e.to_mepc) return {mepc_i[31:2], 2'b00};
    b = {mtvec_i[31:2], 2'b00};
    if (vec && e.irq && mtvec_i[1:0] == 2'd1) return b + 32'(e.cause) * 4;
    return b;
  endfunction

  task automatic check_dut(string tag, bit vec, exp_t e,
                           logic fl, logic st, logic we, logic mr, logic rd,
                           logic [31:0] mc, logic [31:0] me, logic [31:0] mt,
                           logic [31:0] tg);
    chk({tag, " flush"}, fl, e.flush);
    chk({tag, " stall"}, st, e.stall);
    chk({tag, " csr_we"}, we, e.we);
    chk({tag, " mret"}, mr, e.mret);
    chk({tag, " redirect"}, rd, e.redir);
    if (e.we) begin
      chk({tag, " mcause"}, mc, e.mcause);
      chk({tag, " mepc"}, me, e.mepc);
      chk({tag, " mtval"}, mt, e.mtval);
    end
    if (e.redir) chk({tag, " target"}, tg, target(e, vec));
  endtask

  exp_t        m_e, m_s;
  logic        m_exc;
  logic [4:0]  m_c;
  logic [31:0] m_tv;
  logic [2:0]  m_p;

  always @(negedge clk_i) begin
    m_e = '0;
    if (rst_i) begin
      q.delete();
    end else if (q.size() != 0) begin
      m_e = q.pop_front();
    end else if (wb_valid_i) begin
      m_exc = 1'b1;
      m_c   = 5'd0;
      m_tv  = 32'd0;
      if (e_ia)       begin m_c = 5'd0; m_tv = wb_mem_addr_i; end
      else if (e_ill) begin m_c = 5'd2; m_tv = wb_inst_i;     end
      else if (e_ld)  begin m_c = 5'd4; m_tv = wb_mem_addr_i; end
      else if (e_st)  begin m_c = 5'd6; m_tv = wb_mem_addr_i; end
      else m_exc = 1'b0;
      m_p = {meip & mie_i[2], mtip & mie_i[1], msip & mie_i[0]};
      m_s = '0;
      if (!m_exc && is_mret_i) begin
        m_e.flush = 1'b1;
        m_s.flush = 1'b1; m_s.mret = 1'b1; m_s.redir = 1'b1; m_s.to_mepc = 1'b1;
        q.push_back(m_s);
      end else if (m_exc || (mstatus_mie_i && m_p != 3'b000)) begin
        if (!m_exc) m_c = m_p[2] ? 5'd11 : (m_p[0] ? 5'd3 : 5'd7);
        m_e.flush = 1'b1;
        m_s.flush = 1'b1; m_s.stall = 1'b1; m_s.we = 1'b1;
        m_s.mcause = {~m_exc, 26'd0, m_c};
        m_s.mepc = wb_pc_i; m_s.mtval = m_tv;
        q.push_back(m_s);
        m_s = '0;
        m_s.flush = 1'b1; m_s.redir = 1'b1; m_s.irq = ~m_exc; m_s.cause = m_c;
        q.push_back(m_s);
      end
    end
    check_dut("vec", 1'b1, m_e, flush_v, stall_v, we_v, mret_v, redir_v,
              mcause_v, mepc_v, mtval_v, tgt_v);
    check_dut("dir", 1'b0, m_e, flush_d, stall_d, we_d, mret_d, redir_d,
              mcause_d, mepc_d, mtval_d, tgt_d);
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic clear_inputs();
    wb_valid_i = 1'b0; is_mret_i = 1'b0;
    e_ia = 1'b0; e_ill = 1'b0; e_ld = 1'b0; e_st = 1'b0;
    meip = 1'b0; mtip = 1'b0; msip = 1'b0;
  endtask

  // Called #1 after the detect edge with inputs already applied.
  task automatic trap_seq(string nm, logic [31:0] mc, logic [31:0] me,
                          logic [31:0] mt, logic [31:0] t_v, logic [31:0] t_d);
    #1;
    chk({nm, " T flush"}, flush_v, 1'b1);
    chk({nm, " T csr_we"}, we_v, 1'b0);
    @(posedge clk_i); #1; clear_inputs(); #1;
    chk({nm, " T+1 csr_we"}, we_v, 1'b1);
    chk({nm, " T+1 stall"}, stall_v, 1'b1);
    chk({nm, " T+1 mcause"}, mcause_v, mc);
    chk({nm, " T+1 mepc"}, mepc_v, me);
    chk({nm, " T+1 mtval"}, mtval_v, mt);
    chk({nm, " T+1 mret"}, mret_v, 1'b0);
    chk({nm, " T+1 redirect"}, redir_v, 1'b0);
    @(posedge clk_i); #2;
    chk({nm, " T+2 redirect"}, redir_v, 1'b1);
    chk({nm, " T+2 target vec"}, tgt_v, t_v);
    chk({nm, " T+2 target dir"}, tgt_d, t_d);
    chk({nm, " T+2 csr_we"}, we_v, 1'b0);
    @(posedge clk_i); #2;
    chk({nm, " T+3 redirect"}, redir_v, 1'b0);
    chk({nm, " T+3 flush"}, flush_v, 1'b0);
  endtask

  initial begin
    #2;
    chk("reset flush", flush_v, 1'b0);
    chk("reset redirect", redir_v, 1'b0);
    chk("reset mcause", mcause_v, 32'd0);
    chk("reset target", tgt_v, 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1; rst_i = 1'b0;

    // Illegal instruction
    @(posedge clk_i); #1;
    mtvec_i = 32'h200; wb_valid_i = 1'b1; wb_pc_i = 32'h100;
    wb_inst_i = 32'hFFFF_FFFF; e_ill = 1'b1;
    trap_seq("illegal", 32'd2, 32'h100, 32'hFFFF_FFFF, 32'h200, 32'h200);

    // Illegal beats load-misaligned
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_pc_i = 32'h140; wb_inst_i = 32'hDEAD_BEEF;
    wb_mem_addr_i = 32'h1003; e_ill = 1'b1; e_ld = 1'b1;
    trap_seq("ill+ld", 32'd2, 32'h140, 32'hDEAD_BEEF, 32'h200, 32'h200);

    // Fetch-misaligned beats illegal
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_pc_i = 32'h144; e_ia = 1'b1; e_ill = 1'b1;
    trap_seq("ia+ill", 32'd0, 32'h144, 32'h1003, 32'h200, 32'h200);

    // Timer interrupt, vectored mtvec
    @(posedge clk_i); #1;
    mtvec_i = 32'h201; wb_valid_i = 1'b1; wb_pc_i = 32'h180;
    mtip = 1'b1; mie_i = 3'b010; mstatus_mie_i = 1'b1;
    trap_seq("mti", 32'h8000_0007, 32'h180, 32'h0, 32'h21C, 32'h200);

    // All pending, globally masked: nothing happens
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; meip = 1'b1; mtip = 1'b1; msip = 1'b1;
    mie_i = 3'b111; mstatus_mie_i = 1'b0;
    #1; chk("masked flush", flush_v, 1'b0);
    @(posedge clk_i); #2; chk("masked csr_we", we_v, 1'b0);
    clear_inputs();

    // mret
    @(posedge clk_i); #1;
    mepc_i = 32'h104; wb_valid_i = 1'b1; is_mret_i = 1'b1;
    #1; chk("mret T flush", flush_v, 1'b1);
    @(posedge clk_i); #1; clear_inputs(); #1;
    chk("mret T+1 mret", mret_v, 1'b1);
    chk("mret T+1 redirect", redir_v, 1'b1);
    chk("mret T+1 target", tgt_v, 32'h104);
    chk("mret T+1 csr_we", we_v, 1'b0);
    @(posedge clk_i); #2; chk("mret T+2 redirect", redir_v, 1'b0);

    // All pending, enabled: MEI wins
    @(posedge clk_i); #1;
    mtvec_i = 32'h200; wb_valid_i = 1'b1; wb_pc_i = 32'h1C0;
    meip = 1'b1; mtip = 1'b1; msip = 1'b1; mie_i = 3'b111; mstatus_mie_i = 1'b1;
    trap_seq("mei", 32'h8000_000B, 32'h1C0, 32'h0, 32'h200, 32'h200);

    // mret with illegal on the same instruction: exception wins
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_pc_i = 32'h1D0; wb_inst_i = 32'h3020_0073;
    is_mret_i = 1'b1; e_ill = 1'b1;
    trap_seq("mret+ill", 32'd2, 32'h1D0, 32'h3020_0073, 32'h200, 32'h200);

    // Reset during SAVE aborts the trap
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_pc_i = 32'h1E0; e_ill = 1'b1;
    @(posedge clk_i); #1; clear_inputs(); #1;
    chk("rst pre csr_we", we_v, 1'b1);
    rst_i = 1'b1; #1;
    chk("rst async csr_we", we_v, 1'b0);
    chk("rst async flush", flush_v, 1'b0);
    chk("rst async stall", stall_v, 1'b0);
    chk("rst async mcause", mcause_v, 32'd0);
    @(posedge clk_i); #1; rst_i = 1'b0; #1;
    chk("rst post redirect", redir_v, 1'b0);
    @(posedge clk_i); #2; chk("rst post2 redirect", redir_v, 1'b0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #1;
      wb_valid_i    = ($urandom_range(0, 1) == 1);
      wb_pc_i       = $urandom;
      wb_inst_i     = $urandom;
      wb_mem_addr_i = $urandom;
      e_ia  = ($urandom_range(0, 9) == 0);
      e_ill = ($urandom_range(0, 7) == 0);
      e_ld  = ($urandom_range(0, 7) == 0);
      e_st  = ($urandom_range(0, 7) == 0);
      is_mret_i = ($urandom_range(0, 5) == 0);
      meip = ($urandom_range(0, 3) == 0);
      mtip = ($urandom_range(0, 3) == 0);
      msip = ($urandom_range(0, 3) == 0);
      mie_i = 3'($urandom);
      mstatus_mie_i = ($urandom_range(0, 1) == 1);
      mtvec_i = $urandom;
      mepc_i  = $urandom;
    end
    @(posedge clk_i); #1; clear_inputs();
    repeat (5) @(posedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the write-back stage. It arbitrates synchronous exceptions and machine interrupts against the instruction currently in WB, and picks a single trap cause by fixed priority. It then sequences the CSR trap-state update (mcause/mepc/mtval) and the PC redirect to mtvec. It also sequences `mret` returns to mepc, and owns the pipeline flush and stall used during both sequences.

## Interface
Parameters:
- VEC_MODE_EN, 1, when 1, interrupts honour mtvec vectored mode (mtvec[1:0]==1); when 0, all traps go to the direct base.

Ports (reset is asynchronous and active-high):
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- wb_valid_i  in  1  WB holds a valid, not-yet-retired instruction
- wb_pc_i  in  32  PC of the WB instruction
- wb_inst_i  in  32  instruction word in WB
- wb_mem_addr_i  in  32  load/store address, or jump target for a misaligned fetch
- e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i  in  1 each  exception flags from upstream
- is_mret_i  in  1  WB instruction is `mret`
- xint_meip_i, xint_mtip_i, xint_msip_i  in  1 each  level-sensitive interrupt pending lines
- mstatus_mie_i  in  1  global interrupt enable
- mie_i  in  3  {meie, mtie, msie}
- mtvec_i  in  32  current mtvec CSR
- mepc_i  in  32  current mepc CSR
- flush_o  out  1  kill WB/younger instructions, which suppresses the RF write
- stall_o  out  1  hold fetch/decode
- csr_we_exc_o  out  1  one-cycle strobe that writes mcause/mepc/mtval and performs the mstatus trap update
- mcause_o, mepc_o, mtval_o  out  32 each  values to write; valid while csr_we_exc_o is high
- mret_o  out  1  one-cycle strobe that restores mstatus.MIE from MPIE
- pc_redirect_o  out  1  one-cycle strobe that loads the PC
- pc_target_o  out  32  redirect target; valid while pc_redirect_o is high

## Operation
- FSM states: IDLE, SAVE, JUMP, MRET.
- IDLE evaluates the inputs only when wb_valid_i=1. In all other states wb_valid_i and every input flag are ignored.
- Exception priority, highest first:
  - inst_addr_mis: cause 0, mtval = wb_mem_addr_i
  - illegal: cause 2, mtval = wb_inst_i
  - ld_mis: cause 4, mtval = wb_mem_addr_i
  - st_mis: cause 6, mtval = wb_mem_addr_i
- An interrupt is taken only when mstatus_mie_i=1, no exception is present, and (pending & enabled) is non-zero.
  - Interrupt priority: MEI (11) > MSI (3) > MTI (7).
  - mcause_o[31]=1 and mtval_o=0.
- Trap or interrupt in IDLE:
  - Capture cause, tval and epc=wb_pc_i into registers.
  - Assert flush_o combinationally in the same cycle.
  - Next state is SAVE.
- SAVE: csr_we_exc_o=1, stall_o=1, flush_o=1. Next state is JUMP.
- JUMP: pc_redirect_o=1, flush_o=1. pc_target_o is computed as follows, then next state is IDLE.
  - Direct mode: {mtvec_i[31:2], 2'b00}.
  - Vectored mode (interrupt and VEC_MODE_EN=1): base + (cause << 2), computed as 32-bit with wrap.
  - Exceptions always use the base.
- mret in IDLE (wb_valid_i & is_mret_i & no exception): flush_o=1 and next state is MRET. An exception on the same instruction wins over mret.
- MRET: mret_o=1, pc_redirect_o=1, pc_target_o = {mepc_i[31:2], 2'b00} sampled in this cycle, flush_o=1. Next state is IDLE.
- mret has priority over a pending interrupt in the same cycle. The interrupt is re-evaluated in IDLE after the return.
- mtvec_i[1:0] values 2 and 3 are treated as direct mode.

## Timing
- Reset values: state=IDLE; every output 0; captured cause/tval/epc registers 0.
- Asserting rst_i at any point, including during SAVE, JUMP or MRET, aborts immediately: no csr_we_exc_o, no pc_redirect_o.
- Trap detected in cycle T:
  - T: flush_o
  - T+1: csr_we_exc_o (with stall_o)
  - T+2: pc_redirect_o
  - T+3: IDLE, new instruction accepted
- mret detected in cycle T: T flush_o; T+1 mret_o and pc_redirect_o; T+2 IDLE.
- Output classes:
  - Combinational: flush_o in IDLE only.
  - Registered state decode: every other output.
- Interrupt lines are sampled only in IDLE. An interrupt that drops during SAVE or JUMP still completes the trap.

## Structure
- Shared package `trap_pkg` holds:
  - cause codes (CAUSE_INST_MIS=0, ILLEGAL=2, LD_MIS=4, ST_MIS=6, MSI=3, MTI=7, MEI=11)
  - the FSM state encoding
  - mtvec mode constants (DIRECT=0, VECTORED=1)
- One sub-module: `trap_prio_enc`, a combinational encoder whose outputs are trap_valid, is_irq, cause[4:0] and tval[31:0]. The FSM lives in trap_ctrl.

## Test plan
- Illegal instruction: wb_pc 0x100, inst 0xFFFFFFFF, mtvec 0x200.
  - Required: flush at T; T+1 csr_we_exc with mcause 2, mepc 0x100, mtval 0xFFFFFFFF; T+2 redirect to 0x200.
- Illegal and ld_mis together (addr 0x1003): mcause 2, mtval = instruction. Inst_mis together with illegal: mcause 0, mtval = wb_mem_addr_i.
- MTI pending, mie=3'b010, MIE=1, mtvec 0x201, VEC_MODE_EN=1: mcause 0x80000007, mtval 0, target 0x21C. Same with VEC_MODE_EN=0: target 0x200.
- Interrupt masking and mret:
  - All three interrupts pending with MIE=0: no trap.
  - mret with mepc 0x104: flush at T; T+1 mret_o and redirect to 0x104.
  - MEI+MSI+MTI pending with MIE=1: cause 11.
- mret with illegal asserted on the same instruction: trap sequence (mcause 2), no mret_o.
- rst_i pulsed during SAVE: all outputs 0 asynchronously; after release the FSM is IDLE and no redirect occurs.
